// File: rtl/fb_pixel_writer_pkg.sv
// rtl/fb_pixel_writer_pkg.sv - shared types and widths for the framebuffer pixel writer
package fb_writer_pkg;

    localparam int GRAY_W  = 4;
    localparam int ENTRY_W = GRAY_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        ENTER,
        PTR_RST,
        ISSUE,
        WAIT_ACK,
        EXIT
    } state_t;

    typedef struct packed {
        logic              sof;
        logic [GRAY_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/fb_pixel_writer_if.sv
// rtl/fb_pixel_writer_if.sv - pixel stream in, QSPI framebuffer write handshake out
interface fb_pixel_writer_if;
    import fb_writer_pkg::*;

    logic              pix_valid;
    logic [GRAY_W-1:0] pix_data;
    logic              pix_sof;
    logic              pix_ready;
    logic              flush;
    logic              write_mode;
    logic [GRAY_W-1:0] write_data_in;
    logic              reset_write_ptr;
    logic              write_data;
    logic              wrote_data;
    logic              busy;
    logic              ack_err;

    modport master (
        output pix_valid, pix_data, pix_sof, flush, wrote_data,
        input  pix_ready, write_mode, write_data_in, reset_write_ptr, write_data, busy, ack_err
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof, flush, wrote_data,
        output pix_ready, write_mode, write_data_in, reset_write_ptr, write_data, busy, ack_err
    );

endinterface

// File: rtl/fb_pixel_writer_fifo.sv
// rtl/fb_pixel_writer_fifo.sv - synchronous FIFO with count and a peek at the entry behind the head
module sync_fifo #(
    parameter int WIDTH   = 5,
    parameter int DEPTH   = 8,
    parameter int TAG_BIT = WIDTH - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_next_tag,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    w_rd_next;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full     = (r_count == FULL_CNT);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign w_push_ok  = i_push & ~o_full;
    assign w_pop_ok   = i_pop & ~o_empty;
    assign w_rd_next  = r_rd_ptr + AW'(1);
    assign o_data     = r_mem[r_rd_ptr];
    // Lets the consumer see a flag of the entry that becomes head after a pop.
    assign o_next_tag = r_mem[w_rd_next][TAG_BIT];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - buffers gray pixels and writes them to the framebuffer driver in bursts
module fb_pixel_writer
    import fb_writer_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int BURST_LEN      = 4,
    parameter int PTR_RST_CYCLES = 4,
    parameter int ACK_TIMEOUT    = 63,
    parameter int EXIT_GAP       = 2
) (
    input  logic             clk,
    input  logic             rst,
    fb_pixel_writer_if.slave bus
);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_MAX = (ACK_TIMEOUT > PTR_RST_CYCLES) ? ACK_TIMEOUT : PTR_RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int GAP_W   = $clog2(EXIT_GAP + 2);

    state_t           r_state;
    state_t           w_state_next;
    entry_t           w_head;
    logic [CW-1:0]    w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_next_sof;
    logic             w_push;
    logic             w_pop;
    logic             w_last_pop;
    logic             w_new_head_sof;
    logic             w_waiting;
    logic             w_timeout;
    logic [CNT_W-1:0] r_cnt;
    logic [GAP_W-1:0] r_gap;
    logic             r_flush_pend;
    logic             r_ack_err;

    sync_fifo #(
        .WIDTH   (ENTRY_W),
        .DEPTH   (FIFO_DEPTH),
        .TAG_BIT (ENTRY_W - 1)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_data     ({bus.pix_sof, bus.pix_data}),
        .i_pop      (w_pop),
        .o_data     (w_head),
        .o_next_tag (w_next_sof),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign w_push     = bus.pix_valid & ~w_full;
    assign w_pop      = (r_state == WAIT_ACK) & bus.wrote_data;
    assign w_last_pop = w_pop & (w_count == CW'(1)) & ~w_push;
    // With a single entry left, the next head is whatever is being pushed this cycle.
    assign w_new_head_sof = (w_count > CW'(1)) ? w_next_sof : bus.pix_sof;
    assign w_waiting  = (r_state == ENTER) || (r_state == WAIT_ACK);
    assign w_timeout  = w_waiting & ~bus.wrote_data & (r_cnt == CNT_W'(ACK_TIMEOUT));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_gap == '0 &&
                    (w_count >= CW'(BURST_LEN) || (r_flush_pend && !w_empty))) begin
                    w_state_next = ENTER;
                end
            end
            ENTER: begin
                if (bus.wrote_data) begin
                    w_state_next = w_head.sof ? PTR_RST : ISSUE;
                end else if (w_timeout) begin
                    w_state_next = EXIT;
                end
            end
            PTR_RST: begin
                if (r_cnt == CNT_W'(PTR_RST_CYCLES - 1)) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: w_state_next = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.wrote_data) begin
                    if (w_last_pop) begin
                        w_state_next = EXIT;
                    end else if (w_new_head_sof) begin
                        w_state_next = PTR_RST;
                    end else begin
                        w_state_next = ISSUE;
                    end
                end else if (w_timeout) begin
                    w_state_next = EXIT;
                end
            end
            EXIT:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // One counter serves both the pointer-reset hold and the ack timeout; it restarts per state.
    always_ff @(posedge clk) begin
        if (rst || w_state_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state inside {ENTER, PTR_RST, WAIT_ACK}) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap        <= '0;
            r_flush_pend <= 1'b0;
            r_ack_err    <= 1'b0;
        end else begin
            if (r_state == EXIT) begin
                r_gap <= GAP_W'(EXIT_GAP);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end
            if (bus.flush) begin
                r_flush_pend <= 1'b1;
            end else if (w_last_pop) begin
                r_flush_pend <= 1'b0;
            end
            if (w_timeout) begin
                r_ack_err <= 1'b1;
            end
        end
    end

    assign bus.pix_ready       = ~w_full;
    assign bus.write_mode      = r_state inside {ENTER, PTR_RST, ISSUE, WAIT_ACK};
    assign bus.write_data_in   = w_head.data;
    assign bus.reset_write_ptr = (r_state == PTR_RST);
    assign bus.write_data      = (r_state == ISSUE);
    assign bus.busy            = (r_state != IDLE);
    assign bus.ack_err         = r_ack_err;

endmodule
